rf_wb_arbiter: RTL
==================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port between two writers: the main pipeline writeback stage and the multi-cycle mul/div unit.
- The pipeline always has priority and never stalls.
- Mul/div results that lose arbitration are held in a small in-order FIFO and drained when the port is free.
- pend_mask exports the set of GPRs with queued writes, so decode can stall on RAW/WAW hazards.

Parameters:
DEPTH, 2, mul/div buffer entries; power of two, 2..4
CNT_W, $clog2(DEPTH)+1, width of buf_count

Ports:
clk  in  1  clock; all state updates on posedge
resetn  in  1  asynchronous active-low reset
pipe_wen  in  1  pipeline writeback request; no handshake, always serviced
pipe_wreg  in  5  pipeline destination GPR
pipe_wdata  in  32  pipeline write data
md_valid  in  1  mul/div result valid
md_wreg  in  5  mul/div destination GPR
md_wdata  in  32  mul/div result
md_ready  out  1  arbiter can accept a mul/div result this cycle
rf_wen  out  1  register file write enable
rf_wreg  out  5  register file write address
rf_wdata  out  32  register file write data
pend_mask  out  32  bit r set = live queued write to GPR r
buf_count  out  CNT_W  occupied buffer entries, including killed entries

Behaviour:
- Reset (async, resetn=0):
  - Head/tail pointers, count and all entry valid/kill bits clear immediately.
  - md_ready=0, rf_wen=0, pend_mask=0, buf_count=0 while reset is asserted.
  - A reset mid-operation discards every buffered result.
- Buffer entry contents: {wreg, wdata, kill}. FIFO order is strict.
- md_ready = resetn && (count < DEPTH). This is combinational from registered count and does not depend on a same-cycle pop. Accept = md_valid && md_ready.
- Port selection is combinational, evaluated in priority order:
  1. pipe_wen && pipe_wreg!=0: drive pipe_* to rf_*, rf_wen=1.
  2. Otherwise, buffer non-empty and head not killed: drive head to rf_*, rf_wen=1, pop head.
  3. Otherwise, buffer empty and accept and md_wreg!=0 and md not killed (see below): flow-through md_* to rf_*, rf_wen=1, no push. Latency 0 cycles.
  4. Otherwise rf_wen=0. rf_wreg and rf_wdata are don't-care; drive 0.
- Killed head: popped in the same cycle regardless of port use. It never writes. This happens at most once per cycle and counts as the cycle's pop.
- Push: on accept with md_wreg!=0, when not flow-through and not killed at arrival.
  - Accepted results with md_wreg==0 are dropped; they still complete the handshake.
  - Push and pop may occur in the same cycle; count is unchanged.
  - With DEPTH entries full, md_ready=0 and nothing is pushed even if the head pops that cycle.
- Kill rule:
  - Ordering: a mul/div result is always older than a concurrent or later pipeline write.
  - When pipe_wen && pipe_wreg!=0, every buffered entry with wreg==pipe_wreg sets kill at the posedge.
  - A same-cycle accepted md with md_wreg==pipe_wreg is dropped, not pushed.
- pipe_wen with pipe_wreg==0: rf_wen is not asserted for it, and the port is free for the buffer or md.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- pend_mask: OR over valid, non-killed entries of one-hot(wreg), computed from registered state. It does not include a same-cycle flow-through write.
- Invariant: at most one rf write per cycle. Buffered entries write in acceptance order.

Test Plan:
1. Reset then idle -> md_ready=1, rf_wen=0, buf_count=0, pend_mask=0.
2. md_valid, md_wreg=5, md_wdata=32'hA5A5_0001, pipe idle, buffer empty -> same cycle rf_wen=1, rf_wreg=5, rf_wdata=32'hA5A5_0001; buf_count stays 0.
3. pipe_wen every cycle to r1 while md writes r3 then r4 (DEPTH=2) -> buf_count=2, pend_mask=32'h18, md_ready=0. Third md held. Drop pipe_wen -> r3 is written, then r4, in consecutive cycles; md_ready returns to 1 after the first pop.
4. Buffer holds r7 = 32'h11; pipe writes r7 = 32'h22 -> pend_mask bit7 clears next cycle, the entry pops without a write, and the final GPR7 is 32'h22.
5. Same cycle: pipe_wen r9 = 32'hBEEF and md r9 = 32'hDEAD -> rf writes 32'hBEEF, md is accepted and dropped, buf_count=0.
6. Buffer full (r2, r6); resetn pulsed low mid-cycle -> md_ready, rf_wen, buf_count and pend_mask go 0 asynchronously. After release, no stale r2/r6 write occurs.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the single register-file write port between the
// pipeline writeback stage (always wins) and the mul/div unit. Mul/div
// results that lose are queued in a small in-order buffer and drained when
// the port is free. Later pipeline writes to the same GPR kill queued entries.

// One buffer slot: holds {wreg, wdata, kill} plus a valid bit.
module rf_wb_entry (
  input  logic        clk,
  input  logic        resetn,
  input  logic        push,
  input  logic        pop,
  input  logic        kill_en,
  input  logic [4:0]  kill_reg,
  input  logic [4:0]  in_wreg,
  input  logic [31:0] in_wdata,
  output logic        valid,
  output logic        kill,
  output logic [4:0]  wreg,
  output logic [31:0] wdata
);

  // Push loads a fresh live entry; pop frees it; a younger pipeline write to
  // the same GPR marks the entry dead so it drains without writing.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid <= 1'b0;
      kill  <= 1'b0;
      wreg  <= '0;
      wdata <= '0;
    end else if (push) begin
      valid <= 1'b1;
      kill  <= 1'b0;
      wreg  <= in_wreg;
      wdata <= in_wdata;
    end else if (pop) begin
      valid <= 1'b0;
      kill  <= 1'b0;
    end else if (valid && kill_en && (wreg == kill_reg)) begin
      kill  <= 1'b1;
    end
  end

endmodule

module rf_wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             pipe_wen,
  input  logic [4:0]       pipe_wreg,
  input  logic [31:0]      pipe_wdata,
  input  logic             md_valid,
  input  logic [4:0]       md_wreg,
  input  logic [31:0]      md_wdata,
  output logic             md_ready,
  output logic             rf_wen,
  output logic [4:0]       rf_wreg,
  output logic [31:0]      rf_wdata,
  output logic [31:0]      pend_mask,
  output logic [CNT_W-1:0] buf_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]           head, tail;
  logic [CNT_W-1:0]           count;
  logic [DEPTH-1:0]           e_valid, e_kill;
  logic [DEPTH-1:0][4:0]      e_wreg;
  logic [DEPTH-1:0][31:0]     e_wdata;

  logic pipe_act, head_v, head_kill, accept, md_killed, flow, push, pop;

  assign pipe_act  = pipe_wen && (pipe_wreg != 5'd0);
  assign head_v    = (count != '0);
  assign head_kill = e_kill[head];
  // Ready looks only at registered occupancy, never at a same-cycle pop.
  assign md_ready  = resetn && (count < CNT_W'(DEPTH));
  assign accept    = md_valid && md_ready;
  // The md result is older than a same-cycle pipeline write to its GPR.
  assign md_killed = pipe_act && (md_wreg == pipe_wreg);
  assign flow      = !pipe_act && !head_v && accept && (md_wreg != 5'd0);
  // A killed head always drains; a live head drains only when the pipe is idle.
  assign pop       = head_v && (head_kill || !pipe_act);
  assign push      = accept && (md_wreg != 5'd0) && !flow && !md_killed;
  assign buf_count = count;

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_ent
      rf_wb_entry u_ent (
        .clk      (clk),
        .resetn   (resetn),
        .push     (push && (tail == PTR_W'(g))),
        .pop      (pop && (head == PTR_W'(g))),
        .kill_en  (pipe_act),
        .kill_reg (pipe_wreg),
        .in_wreg  (md_wreg),
        .in_wdata (md_wdata),
        .valid    (e_valid[g]),
        .kill     (e_kill[g]),
        .wreg     (e_wreg[g]),
        .wdata    (e_wdata[g])
      );
    end
  endgenerate

  // Port select in priority order: pipeline, live head, md flow-through.
  always_comb begin
    rf_wen   = 1'b0;
    rf_wreg  = '0;
    rf_wdata = '0;
    if (resetn) begin
      if (pipe_act) begin
        rf_wen   = 1'b1;
        rf_wreg  = pipe_wreg;
        rf_wdata = pipe_wdata;
      end else if (head_v && !head_kill) begin
        rf_wen   = 1'b1;
        rf_wreg  = e_wreg[head];
        rf_wdata = e_wdata[head];
      end else if (flow) begin
        rf_wen   = 1'b1;
        rf_wreg  = md_wreg;
        rf_wdata = md_wdata;
      end
    end
  end

  // Pending-write mask over live queued entries, from registered state only.
  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (e_valid[i] && !e_kill[i]) pend_mask[e_wreg[i]] = 1'b1;
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule
